// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780-style 8-bit LCD write bus between two
// byte requesters. It serialises writes and times RS/data setup, the E pulse
// and the post-write execution wait. A requester can lock the bus for the
// length of a multi-byte packet; an idle lock is force-released after a timeout.
module lcd_bus_arbiter #(
  parameter int SETUP_CYC     = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int WAIT_CYC      = 2500,
  parameter int LONG_WAIT_CYC = 100000,
  parameter int LOCK_TIMEOUT  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       owner
);

  // One counter width covers every phase length and the lock timeout.
  localparam int MAX_A   = (WAIT_CYC > LONG_WAIT_CYC) ? WAIT_CYC : LONG_WAIT_CYC;
  localparam int MAX_B   = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int MAX_C   = (MAX_B > SETUP_CYC) ? MAX_B : SETUP_CYC;
  localparam int MAX_CYC = (MAX_C > E_HIGH_CYC) ? MAX_C : E_HIGH_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Terminal counts: each phase lasts N cycles, so it ends when the count is N-1.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LWAIT_LAST = CNT_W'(LONG_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT   = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] tcnt_r;
  logic             lock_r;
  logic             owner_r;
  logic             long_wait_r;
  logic             lcd_rs_r;
  logic [7:0]       lcd_data_r;
  logic             lcd_e_r;

  logic             gnt_valid_s;
  logic             gnt_id_s;
  logic             accept_s;
  logic             sel_rs_s;
  logic [7:0]       sel_data_s;
  logic             sel_last_s;
  logic             long_cmd_s;
  logic             owner_valid_s;
  logic             timeout_fire_s;
  logic [CNT_W-1:0] wait_last_s;

  // Clear (0x01) and return-home (0x02/0x03) commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) &&
           ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  assign owner_valid_s  = owner_r ? req1_valid : req0_valid;
  assign timeout_fire_s = (state_r == ST_IDLE) && lock_r && (tcnt_r == TO_LIMIT);
  assign wait_last_s    = long_wait_r ? LWAIT_LAST : WAIT_LAST;
  assign accept_s       = gnt_valid_s;

  // Grant: locked owner only; else the sole requester; on a tie the non-owner.
  // A firing lock timeout suppresses the grant so the tie is re-evaluated next cycle.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_id_s    = 1'b0;
    if ((state_r == ST_IDLE) && !timeout_fire_s) begin
      if (lock_r) begin
        gnt_id_s    = owner_r;
        gnt_valid_s = owner_valid_s;
      end else if (req0_valid && req1_valid) begin
        gnt_id_s    = ~owner_r;
        gnt_valid_s = 1'b1;
      end else if (req0_valid) begin
        gnt_id_s    = 1'b0;
        gnt_valid_s = 1'b1;
      end else if (req1_valid) begin
        gnt_id_s    = 1'b1;
        gnt_valid_s = 1'b1;
      end else begin
        gnt_valid_s = 1'b0;
      end
    end else begin
      gnt_valid_s = 1'b0;
    end
  end

  // Select the granted requester's byte attributes.
  always_comb begin
    sel_rs_s   = 1'b0;
    sel_data_s = 8'h00;
    sel_last_s = 1'b0;
    if (gnt_id_s) begin
      sel_rs_s   = req1_rs;
      sel_data_s = req1_data;
      sel_last_s = req1_last;
    end else begin
      sel_rs_s   = req0_rs;
      sel_data_s = req0_data;
      sel_last_s = req0_last;
    end
    long_cmd_s = is_long_cmd(sel_rs_s, sel_data_s);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state: accept -> setup -> E pulse -> execution wait -> idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = ST_PULSE;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_PULSE: begin
        if (cnt_r == E_LAST) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_PULSE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == wait_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE for the granted requester; busy outside IDLE.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req0_ready = gnt_valid_s && !gnt_id_s;
        req1_ready = gnt_valid_s && gnt_id_s;
        busy       = 1'b0;
      end
      ST_SETUP, ST_PULSE, ST_WAIT: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Phase counter: restarts on every state change, parked at zero in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if ((state_s != state_r) || (state_r == ST_IDLE)) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // E is registered from the next state so it is high exactly while in PULSE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_e_r <= 1'b0;
    end else begin
      lcd_e_r <= (state_s == ST_PULSE);
    end
  end

  // Capture RS/data and the wait length on accept; held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcd_rs_r    <= 1'b0;
      lcd_data_r  <= 8'h00;
      long_wait_r <= 1'b0;
    end else if (accept_s) begin
      lcd_rs_r    <= sel_rs_s;
      lcd_data_r  <= sel_data_s;
      long_wait_r <= long_cmd_s;
    end else begin
      lcd_rs_r    <= lcd_rs_r;
      lcd_data_r  <= lcd_data_r;
      long_wait_r <= long_wait_r;
    end
  end

  // Owner and packet lock: set by accepted bytes, lock dropped by the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= 1'b1;
      lock_r  <= 1'b0;
    end else if (accept_s) begin
      owner_r <= gnt_id_s;
      lock_r  <= !sel_last_s;
    end else if (timeout_fire_s) begin
      owner_r <= owner_r;
      lock_r  <= 1'b0;
    end else begin
      owner_r <= owner_r;
      lock_r  <= lock_r;
    end
  end

  // Lock timeout: counts idle cycles while the locked owner has nothing to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_r <= CNT_ZERO;
    end else if (accept_s || (state_r != ST_IDLE) || timeout_fire_s) begin
      tcnt_r <= CNT_ZERO;
    end else if (lock_r && !owner_valid_s) begin
      tcnt_r <= tcnt_r + CNT_ONE;
    end else begin
      tcnt_r <= tcnt_r;
    end
  end

  assign lcd_rs   = lcd_rs_r;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = lcd_e_r;
  assign lcd_data = lcd_data_r;
  assign owner    = owner_r;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780-style 8-bit LCD write bus between two requesters. Requester 0 is the clock/time display writer; requester 1 is the pill-alarm message writer.
- Serialises byte writes and generates RS/data setup, the E pulse and the post-write execution wait, so requesters no longer need their own 2 ms tick.
- Supports packet locking, so a multi-byte sequence (cursor command plus characters) is never interleaved with the other requester.
- Sits between the display FSMs and the LCD pins.

Parameters:
- SETUP_CYC, 2: clk cycles RS/data are stable before E rises (≥1).
- E_HIGH_CYC, 12: clk cycles E is held high (≥1).
- WAIT_CYC, 2500: clk cycles after E falls before the next write, for normal commands and data (50 µs at 50 MHz).
- LONG_WAIT_CYC, 100000: post-write wait for the clear (0x01) and home (0x02/0x03) commands with RS=0 (2 ms at 50 MHz).
- LOCK_TIMEOUT, 1000000: idle cycles a locked owner may leave its valid low before the lock is force-released.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  requester 0 has a byte.
- req0_rs  in  1  requester 0 RS (0 = command, 1 = data).
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  byte ends requester 0's packet (releases lock).
- req0_ready  out  1  requester 0 byte accepted this cycle when valid is also high.
- req1_valid, req1_rs, req1_data, req1_last, req1_ready: same as requester 0, for requester 1.
- lcd_rs  out  1  LCD RS.
- lcd_rw  out  1  LCD RW, constant 0.
- lcd_e  out  1  LCD enable.
- lcd_data  out  8  LCD data bus.
- busy  out  1  high whenever state != IDLE.
- owner  out  1  requester granted most recently.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - lcd_e = 0, lcd_rs = 0, lcd_data = 0x00.
  - lock = 0, owner = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
  - All ready outputs = 0.
  - Reset mid-pulse drops E at once; the interrupted byte is lost and is not replayed.
- FSM states: IDLE → SETUP → PULSE → WAIT → IDLE.
- Grant, evaluated combinationally in IDLE only:
  - If lock = 1, only the owner is eligible.
  - Otherwise, if exactly one valid is high, that requester is granted.
  - If both are valid, the requester != owner is granted (round-robin per packet).
  - reqN_ready = (state == IDLE) && granted == N. Ready is never high outside IDLE. At most one ready is high per cycle.
- Accept (valid && ready), on that clock edge:
  - Register lcd_rs and lcd_data, set owner = N, enter SETUP.
  - If last = 0, set lock = 1. If last = 1, set lock = 0.
  - Set long_wait = (rs == 0 && data ∈ {0x01, 0x02, 0x03}).
- SETUP: E = 0 for SETUP_CYC cycles, then PULSE.
- PULSE: E = 1 for exactly E_HIGH_CYC cycles, then WAIT.
- WAIT: E = 0 for WAIT_CYC cycles, or LONG_WAIT_CYC if long_wait is set, then IDLE.
- lcd_rs and lcd_data hold the accepted value from the accept edge until the next accept. They do not change during SETUP, PULSE or WAIT.
- Beat period: minimum accept-to-accept spacing is 1 + SETUP_CYC + E_HIGH_CYC + wait cycles. Back-to-back accepts are never possible.
- Lock timeout:
  - In IDLE with lock = 1 and owner valid = 0, the counter increments each cycle.
  - Any accept, or any cycle outside IDLE, clears the counter.
  - When the counter reaches LOCK_TIMEOUT, lock is cleared on the next edge. Owner is unchanged, so the other requester wins the next tie.
- Simultaneous events:
  - A locked owner asserting valid in the same cycle the timeout fires: the timeout wins, lock is cleared, and the grant is re-evaluated next cycle.
  - A requester may drop valid at any time without ready; nothing is accepted.
- Counters are sized from the parameters (clog2 of max(WAIT_CYC, LONG_WAIT_CYC, LOCK_TIMEOUT) + 1) and never wrap.

Test Plan (SETUP_CYC = 2, E_HIGH_CYC = 3, WAIT_CYC = 5, LONG_WAIT_CYC = 20, LOCK_TIMEOUT = 8):
- Reset checks: assert rst during PULSE → lcd_e = 0 in the same cycle. After release: busy = 0, lcd_data = 0x00, and req0 alone valid sees req0_ready = 1 in the first cycle.
- Single data beat: req0 sends rs = 1, 0x41, last = 1 at cycle t.
  - lcd_data = 0x41 and lcd_rs = 1 from t+1.
  - lcd_e high during cycles t+3..t+5.
  - busy low at t+11.
  - Next req0_ready at t+11.
- Clear command: req1 sends rs = 0, 0x01 → E falls, then 20 wait cycles before IDLE; total beat period 26 cycles.
- Round-robin tie: both valid with last = 1 continuously, from reset → grants alternate 0, 1, 0, 1. The first grant is req0.
- Packet lock: req1 sends 0x84 (last = 0), then "P" (last = 0) and "X" (last = 1) while req0 stays valid → req0_ready stays 0 until after "X". The LCD sees the sequence 0x84, 'P', 'X' uninterrupted.
- Lock timeout: req0 sends a byte with last = 0, then drops valid while req1 is valid → after 8 idle cycles the lock clears and req1_ready = 1 on the following cycle.
